// File: rtl/serial_sub_nbit.sv
`timescale 1ns/1ps
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Latency: WIDTH cycles from the accepting edge to the done pulse.
// Backpressure: start is ignored while busy; accepted in IDLE or on the done cycle.
module serial_sub_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             a0;
  logic             b0;
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] r_next;
  logic             last;

  // One full-subtractor slice on the current LSBs and the carried borrow.
  always_comb begin
    a0      = a_sh[0];
    b0      = b_sh[0];
    d       = a0 ^ b0 ^ br;
    br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
    r_next  = {d, r_sh[WIDTH-1:1]};
    last    = (cnt == CW'(WIDTH - 1));
  end

  // Control FSM with shift datapath; diff/bout are only written on the final slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            r_sh  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_next;
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          if (last) begin
            diff  <= r_next;
            bout  <= br_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_nbit.sv
`timescale 1ns/1ps
// Scoreboard bench for serial_sub_nbit at WIDTH=8 and WIDTH=13.
// Stimulus pushes expected {bout, diff}; monitors pop and compare on done.
// Directed vectors plus a randomized sweep against an arithmetic reference.
module tb_serial_sub_nbit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        bin8 = 1'b0;
  logic        busy8, done8, bout8;
  logic [7:0]  diff8;

  logic        start13 = 1'b0;
  logic [12:0] a13 = '0, b13 = '0;
  logic        bin13 = 1'b0;
  logic        busy13, done13, bout13;
  logic [12:0] diff13;

  logic [8:0]  q8[$];
  logic [13:0] q13[$];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  serial_sub_nbit #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_sub_nbit #(.WIDTH(13)) u13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13), .bin(bin13),
    .busy(busy13), .done(done13), .diff(diff13), .bout(bout13)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL done8_unexpected: got done with diff=0x%0h bout=%0b, expected no done", diff8, bout8);
      end else begin
        logic [8:0] e;
        e = q8.pop_front();
        chk("diff8", 32'(diff8), 32'(e[7:0]));
        chk("bout8", 32'(bout8), 32'(e[8]));
      end
    end
  end

  // Monitor for the 13-bit instance.
  always @(negedge clk) begin
    if (done13) begin
      if (q13.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL done13_unexpected: got done with diff=0x%0h bout=%0b, expected no done", diff13, bout13);
      end else begin
        logic [13:0] e;
        e = q13.pop_front();
        chk("diff13", 32'(diff13), 32'(e[12:0]));
        chk("bout13", 32'(bout13), 32'(e[13]));
      end
    end
  end

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                     input logic [7:0] ed, input logic eb, input bit push);
    @(negedge clk);
    a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
    if (push) q8.push_back({eb, ed});
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  task automatic op13(input logic [12:0] av, input logic [12:0] bv, input logic bi,
                      input logic [12:0] ed, input logic eb);
    @(negedge clk);
    a13 = av; b13 = bv; bin13 = bi; start13 = 1'b1;
    q13.push_back({eb, ed});
    @(posedge clk);
    #1 start13 = 1'b0;
  endtask

  // Waits for done on the selected instance; n returns busy cycles seen before it.
  task automatic wait_done(input int sel, output int n);
    bit got;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sel == 8 ? done8 : done13) begin
        got = 1'b1;
        break;
      end
      if (sel == 8 ? busy8 : busy13) n++;
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL timeout%0d: got no done within 40 cycles, expected done", sel);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int dc;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_bout", 32'(bout8), 32'd0);
    rst_n = 1'b1;

    // Directed single operations
    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b1);
    wait_done(8, n);
    chk("busy_len", 32'(n), 32'd8);
    op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b1);
    wait_done(8, n);
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b1);
    wait_done(8, n);
    op8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1);
    wait_done(8, n);

    // Back-to-back: start on the done cycle
    op8(8'h40, 8'h41, 1'b0, 8'hFF, 1'b1, 1'b1);
    wait_done(8, n);
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back({1'b0, 8'h7F});
    @(posedge clk);
    #1 start8 = 1'b0;
    chk("b2b_busy", 32'(busy8), 32'd1);
    chk("b2b_done", 32'(done8), 32'd0);
    @(negedge clk);
    chk("b2b_hold_diff", 32'(diff8), 32'hFF);
    chk("b2b_hold_bout", 32'(bout8), 32'd1);
    wait_done(8, n);
    chk("b2b_busy_len", 32'(n + 1), 32'd8);

    // start during RUN is ignored
    op8(8'h10, 8'h20, 1'b1, 8'hEF, 1'b1, 1'b1);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) dc++;
    end
    chk("ignored_done_cnt", 32'(dc), 32'd1);

    // Asynchronous reset mid-run
    op8(8'h77, 8'h11, 1'b0, 8'h66, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_diff", 32'(diff8), 32'd0);
    chk("abort_bout", 32'(bout8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) dc++;
    end
    chk("abort_no_done", 32'(dc), 32'd0);
    op8(8'h9C, 8'h3A, 1'b1, 8'h61, 1'b0, 1'b1);
    wait_done(8, n);

    // Random sweep, WIDTH=8
    for (int i = 0; i < 500; i++) begin
      logic [7:0] av, bv;
      logic       bi;
      logic [8:0] r;
      av = 8'($urandom);
      bv = 8'($urandom);
      bi = 1'($urandom);
      r  = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
      op8(av, bv, bi, r[7:0], r[8], 1'b1);
      wait_done(8, n);
    end

    // Random sweep, WIDTH=13
    for (int i = 0; i < 500; i++) begin
      logic [12:0] av, bv;
      logic        bi;
      logic [13:0] r;
      av = 13'($urandom);
      bv = 13'($urandom);
      bi = 1'($urandom);
      r  = {1'b0, av} - {1'b0, bv} - {13'd0, bi};
      op13(av, bv, bi, r[12:0], r[13]);
      wait_done(13, n);
      chk("busy13_len", 32'(n), 32'd13);
    end

    repeat (2) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q13_drained", 32'(q13.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
